alu_issue_ctrl: RTL and testbench

Upstream dispatch stage for the ALU. Accepts one decoded operation per handshake from the CU, selects operands (rs1/rs2/immediate), and drives the ALU's dat_ready / ALU_dat1 / ALU_dat2 / Instruction_from_CU interface. It then waits for ALU_ready, captures the result and flags, and presents a one-cycle writeback/branch-resolution result to the CU. It enforces one ALU operation in flight and flags a hung ALU through a timeout.

---
 rtl/alu_issue_ctrl.sv | 166 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// ALU dispatch controller: accepts one decoded op from the CU, drives the ALU
// operand interface, waits for the result and returns a one-cycle writeback strobe.
module alu_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic        soc_clk,
  input  logic        reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [5:0]  instr_code,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [31:0] imm,
  input  logic [31:0] pc,
  output logic        dat_ready,
  output logic [31:0] ALU_dat1,
  output logic [31:0] ALU_dat2,
  output logic [5:0]  Instruction_from_CU,
  input  logic        ALU_ready,
  input  logic [31:0] ALU_out,
  input  logic        ALU_con_met,
  input  logic        ALU_overflow,
  input  logic        ALU_zero,
  output logic        wb_valid,
  output logic        wb_en,
  output logic [31:0] wb_data,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        res_overflow,
  output logic        res_zero,
  output logic        illegal,
  output logic        timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYCLES);

  // state | meaning
  // IDLE  | ready for the next op from the CU
  // ISSUE | dat_ready pulse to the ALU
  // WAIT  | waiting for ALU_ready, timeout counter running
  // DONE  | wb_valid pulse, result outputs updated
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_next;
  logic [5:0]    code_q;
  logic [31:0]   target_q;
  logic          in_branch;
  logic          in_legal;
  logic          q_branch;
  logic [31:0]   dat2_sel;

  function automatic logic code_is_branch(input logic [5:0] c);
    return (c >= 6'd4) && (c <= 6'd9);
  endfunction

  function automatic logic code_is_legal(input logic [5:0] c);
    return code_is_branch(c) || ((c >= 6'd18) && (c <= 6'd36));
  endfunction

  always_comb begin
    in_branch = code_is_branch(instr_code);
    in_legal  = code_is_legal(instr_code);
    q_branch  = code_is_branch(code_q);
    wait_next = wait_cnt + 1'b1;
    dat2_sel  = rs2_val;
    if ((instr_code >= 6'd18) && (instr_code <= 6'd23))
      dat2_sel = imm;
    else if ((instr_code >= 6'd24) && (instr_code <= 6'd26))
      dat2_sel = {27'b0, imm[4:0]};
  end

  always_ff @(posedge soc_clk) begin
    if (reset) begin
      state               <= IDLE;
      wait_cnt            <= '0;
      code_q              <= '0;
      target_q            <= '0;
      issue_ready         <= 1'b1;
      dat_ready           <= 1'b0;
      ALU_dat1            <= '0;
      ALU_dat2            <= '0;
      Instruction_from_CU <= '0;
      wb_valid            <= 1'b0;
      wb_en               <= 1'b0;
      wb_data             <= '0;
      br_taken            <= 1'b0;
      br_target           <= '0;
      res_overflow        <= 1'b0;
      res_zero            <= 1'b0;
      illegal             <= 1'b0;
      timeout_err         <= 1'b0;
    end else begin
      dat_ready <= 1'b0;
      wb_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (issue_valid) begin
            issue_ready <= 1'b0;
            code_q      <= instr_code;
            target_q    <= in_branch ? (pc + imm) : 32'd0;
            if (in_legal) begin
              ALU_dat1            <= rs1_val;
              ALU_dat2            <= dat2_sel;
              Instruction_from_CU <= instr_code;
              dat_ready           <= 1'b1;
              state               <= ISSUE;
            end else begin
              // Unsupported code bypasses the ALU entirely; the buses keep the last op.
              wb_valid     <= 1'b1;
              wb_en        <= 1'b0;
              wb_data      <= '0;
              br_taken     <= 1'b0;
              br_target    <= '0;
              res_overflow <= 1'b0;
              res_zero     <= 1'b0;
              illegal      <= 1'b1;
              state        <= DONE;
            end
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (ALU_ready) begin
            wb_valid     <= 1'b1;
            wb_en        <= !q_branch;
            wb_data      <= q_branch ? 32'd0 : ALU_out;
            br_taken     <= q_branch && ALU_con_met;
            br_target    <= target_q;
            res_overflow <= ALU_overflow;
            res_zero     <= ALU_zero;
            illegal      <= 1'b0;
            state        <= DONE;
          end else if (wait_next == TIMEOUT_VAL) begin
            timeout_err  <= 1'b1;
            wb_valid     <= 1'b1;
            wb_en        <= 1'b0;
            wb_data      <= '0;
            br_taken     <= 1'b0;
            br_target    <= target_q;
            res_overflow <= 1'b0;
            res_zero     <= 1'b0;
            illegal      <= 1'b0;
            state        <= DONE;
          end else begin
            wait_cnt <= wait_next;
          end
        end
        DONE: begin
          issue_ready <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          issue_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a fixed-latency stub ALU.
module tb_alu_issue_ctrl;

  logic        soc_clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  instr_code;
  logic [31:0] rs1_val, rs2_val, imm, pc;
  logic        dat_ready;
  logic [31:0] ALU_dat1, ALU_dat2;
  logic [5:0]  Instruction_from_CU;
  logic        ALU_ready;
  logic [31:0] ALU_out;
  logic        ALU_con_met, ALU_overflow, ALU_zero;
  logic        wb_valid, wb_en, br_taken, res_overflow, res_zero, illegal, timeout_err;
  logic [31:0] wb_data, br_target;

  logic        alu_en = 1'b1;
  logic        stub_ready = 1'b0;
  logic        stray_ready = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  assign ALU_ready = stub_ready | stray_ready;

  always #5 soc_clk = ~soc_clk;

  alu_issue_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .soc_clk(soc_clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .instr_code(instr_code),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .pc(pc),
    .dat_ready(dat_ready), .ALU_dat1(ALU_dat1), .ALU_dat2(ALU_dat2),
    .Instruction_from_CU(Instruction_from_CU),
    .ALU_ready(ALU_ready), .ALU_out(ALU_out), .ALU_con_met(ALU_con_met),
    .ALU_overflow(ALU_overflow), .ALU_zero(ALU_zero),
    .wb_valid(wb_valid), .wb_en(wb_en), .wb_data(wb_data),
    .br_taken(br_taken), .br_target(br_target),
    .res_overflow(res_overflow), .res_zero(res_zero),
    .illegal(illegal), .timeout_err(timeout_err)
  );

  // Stub ALU: result valid three cycles after the dat_ready cycle.
  initial begin
    logic [31:0] a, b, r;
    logic [5:0]  c;
    ALU_out = '0; ALU_con_met = 1'b0; ALU_overflow = 1'b0; ALU_zero = 1'b0;
    forever begin
      @(posedge soc_clk);
      if (dat_ready && alu_en) begin
        a = ALU_dat1; b = ALU_dat2; c = Instruction_from_CU;
        repeat (2) @(posedge soc_clk);
        #1;
        ALU_con_met = 1'b0;
        case (c)
          6'd18, 6'd27: r = a + b;
          6'd26:        r = $unsigned($signed(a) >>> b[4:0]);
          6'd4: begin
            r = a - b;
            ALU_con_met = (a == b);
          end
          default: r = 32'd0;
        endcase
        ALU_out = r;
        ALU_zero = (r == 32'd0);
        stub_ready = 1'b1;
        @(posedge soc_clk);
        #1 stub_ready = 1'b0;
      end
    end
  end

  task automatic issue_op(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] im, input logic [31:0] p);
    int guard = 0;
    @(negedge soc_clk);
    while (!issue_ready && guard < 40) begin
      @(negedge soc_clk);
      guard++;
    end
    if (!issue_ready) begin
      vectors++; miscompares++;
      $display("FAIL issue_ready_wait: issue_ready=%0b required 1", issue_ready);
    end
    instr_code = code; rs1_val = a; rs2_val = b; imm = im; pc = p;
    issue_valid = 1'b1;
    @(posedge soc_clk);
    #1 issue_valid = 1'b0;
  endtask

  // n counts negedges after the accept edge up to and including the wb_valid one.
  task automatic wait_wb(input int lim, output int n, output int dr);
    n = 0; dr = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge soc_clk);
      n++;
      if (dat_ready) dr++;
      if (wb_valid) break;
    end
    if (!wb_valid) begin
      vectors++; miscompares++;
      $display("FAIL wb_valid_wait: wb_valid=%0b required 1 within %0d cycles", wb_valid, lim);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; issue_valid = 1'b0; instr_code = '0;
    rs1_val = '0; rs2_val = '0; imm = '0; pc = '0;
    repeat (3) @(posedge soc_clk);
    #1 reset = 1'b0;
    @(negedge soc_clk);
    vectors++;
    if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL reset_issue_ready: got %0b want 1", issue_ready); end
    vectors++;
    if ({dat_ready, wb_valid, wb_en, br_taken, illegal, timeout_err, res_zero, res_overflow} !== 8'h00) begin
      miscompares++; $display("FAIL reset_flags: got %b want 00000000",
        {dat_ready, wb_valid, wb_en, br_taken, illegal, timeout_err, res_zero, res_overflow});
    end
    vectors++;
    if ({ALU_dat1, ALU_dat2, Instruction_from_CU, wb_data, br_target} !== 134'd0) begin
      miscompares++; $display("FAIL reset_buses: dat1=%h dat2=%h code=%0d wb_data=%h tgt=%h want all 0",
        ALU_dat1, ALU_dat2, Instruction_from_CU, wb_data, br_target);
    end
  endtask

  task automatic test_add;
    int n, dr;
    issue_op(6'd27, 32'd5, 32'd7, 32'h1234, 32'h40);
    wait_wb(20, n, dr);
    vectors++; if (n !== 5) begin miscompares++; $display("FAIL add_latency: got %0d want 5", n); end
    vectors++; if (dr !== 1) begin miscompares++; $display("FAIL add_dat_ready_pulses: got %0d want 1", dr); end
    vectors++; if (ALU_dat2 !== 32'd7) begin miscompares++; $display("FAIL add_dat2: got %h want 7", ALU_dat2); end
    vectors++; if (wb_en !== 1'b1) begin miscompares++; $display("FAIL add_wb_en: got %0b want 1", wb_en); end
    vectors++; if (wb_data !== 32'd12) begin miscompares++; $display("FAIL add_wb_data: got %h want c", wb_data); end
    vectors++; if (res_zero !== 1'b0) begin miscompares++; $display("FAIL add_zero: got %0b want 0", res_zero); end
    vectors++; if ({illegal, br_taken} !== 2'b00) begin miscompares++; $display("FAIL add_illegal_br: got %b want 00", {illegal, br_taken}); end
    @(negedge soc_clk);
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL add_wb_one_cycle: got %0b want 0", wb_valid); end
    vectors++; if (wb_data !== 32'd12) begin miscompares++; $display("FAIL add_wb_hold: got %h want c", wb_data); end
  endtask

  task automatic test_addi;
    int n, dr;
    issue_op(6'd18, 32'hFFFF_FFFF, 32'h55, 32'd1, 32'h0);
    wait_wb(20, n, dr);
    vectors++; if (ALU_dat2 !== 32'd1) begin miscompares++; $display("FAIL addi_dat2: got %h want 1", ALU_dat2); end
    vectors++; if (wb_data !== 32'd0) begin miscompares++; $display("FAIL addi_wb_data: got %h want 0", wb_data); end
    vectors++; if ({res_zero, wb_en} !== 2'b11) begin miscompares++; $display("FAIL addi_zero_en: got %b want 11", {res_zero, wb_en}); end
  endtask

  task automatic test_srai;
    int n, dr;
    issue_op(6'd26, 32'h8000_0000, 32'h55, 32'h0000_0FE3, 32'h0);
    wait_wb(20, n, dr);
    vectors++; if (ALU_dat2 !== 32'd3) begin miscompares++; $display("FAIL srai_dat2: got %h want 3", ALU_dat2); end
    vectors++; if (wb_data !== 32'hF000_0000) begin miscompares++; $display("FAIL srai_wb_data: got %h want f0000000", wb_data); end
  endtask

  task automatic test_branch;
    int n, dr;
    issue_op(6'd4, 32'd9, 32'd9, 32'h20, 32'h100);
    wait_wb(20, n, dr);
    vectors++; if (br_taken !== 1'b1) begin miscompares++; $display("FAIL beq_taken: got %0b want 1", br_taken); end
    vectors++; if (br_target !== 32'h120) begin miscompares++; $display("FAIL beq_target: got %h want 120", br_target); end
    vectors++; if ({wb_en, wb_data} !== 33'd0) begin miscompares++; $display("FAIL beq_wb: en=%0b data=%h want 0/0", wb_en, wb_data); end
    vectors++; if (ALU_dat2 !== 32'd9) begin miscompares++; $display("FAIL beq_dat2: got %h want 9", ALU_dat2); end
    issue_op(6'd4, 32'd9, 32'd8, 32'h20, 32'h100);
    wait_wb(20, n, dr);
    vectors++; if (br_taken !== 1'b0) begin miscompares++; $display("FAIL bne_case_taken: got %0b want 0", br_taken); end
  endtask

  task automatic test_illegal;
    int n, dr;
    issue_op(6'd0, 32'd1, 32'd2, 32'd3, 32'd4);
    wait_wb(10, n, dr);
    vectors++; if (n !== 1) begin miscompares++; $display("FAIL illegal_latency: got %0d want 1", n); end
    vectors++; if ({illegal, wb_en} !== 2'b10) begin miscompares++; $display("FAIL illegal_flags: got %b want 10", {illegal, wb_en}); end
    vectors++; if (dr !== 0) begin miscompares++; $display("FAIL illegal_dat_ready: got %0d want 0", dr); end
    issue_op(6'd10, 32'd1, 32'd2, 32'd3, 32'd4);
    wait_wb(10, n, dr);
    vectors++; if ({n == 1, illegal, dr == 0} !== 3'b111) begin
      miscompares++; $display("FAIL illegal_code10: n=%0d illegal=%0b dr=%0d want 1/1/0", n, illegal, dr);
    end
  endtask

  task automatic test_stray_ready;
    @(negedge soc_clk);
    stray_ready = 1'b1;
    @(negedge soc_clk);
    stray_ready = 1'b0;
    @(negedge soc_clk);
    vectors++; if ({wb_valid, issue_ready} !== 2'b01) begin
      miscompares++; $display("FAIL stray_ready: wb_valid=%0b issue_ready=%0b want 0/1", wb_valid, issue_ready);
    end
  endtask

  task automatic test_timeout;
    int n, dr;
    alu_en = 1'b0;
    issue_op(6'd27, 32'd1, 32'd1, 32'd0, 32'd0);
    wait_wb(30, n, dr);
    vectors++; if (n !== 10) begin miscompares++; $display("FAIL timeout_latency: got %0d want 10", n); end
    vectors++; if ({timeout_err, wb_en} !== 2'b10) begin miscompares++; $display("FAIL timeout_flags: got %b want 10", {timeout_err, wb_en}); end
    alu_en = 1'b1;
    issue_op(6'd27, 32'd20, 32'd22, 32'd0, 32'd0);
    wait_wb(20, n, dr);
    vectors++; if ({timeout_err, wb_en} !== 2'b11 || wb_data !== 32'd42) begin
      miscompares++; $display("FAIL timeout_sticky: err=%0b en=%0b data=%h want 1/1/2a", timeout_err, wb_en, wb_data);
    end
  endtask

  task automatic test_reset_in_wait;
    int n, dr;
    alu_en = 1'b0;
    issue_op(6'd27, 32'd3, 32'd4, 32'd0, 32'd0);
    repeat (3) @(negedge soc_clk);
    reset = 1'b1;
    @(negedge soc_clk);
    reset = 1'b0;
    vectors++; if ({issue_ready, dat_ready, wb_valid, timeout_err} !== 4'b1000) begin
      miscompares++; $display("FAIL reset_in_wait: rdy=%0b dr=%0b wbv=%0b err=%0b want 1/0/0/0",
        issue_ready, dat_ready, wb_valid, timeout_err);
    end
    alu_en = 1'b1;
    issue_op(6'd27, 32'd1, 32'd2, 32'd0, 32'd0);
    wait_wb(20, n, dr);
    vectors++; if (n !== 5 || wb_data !== 32'd3 || wb_en !== 1'b1) begin
      miscompares++; $display("FAIL add_after_reset: n=%0d data=%h en=%0b want 5/3/1", n, wb_data, wb_en);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_addi;
    test_srai;
    test_branch;
    test_illegal;
    test_stray_ready;
    test_timeout;
    test_reset_in_wait;
    repeat (2) @(negedge soc_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
